// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe move entry block: board width,
// entry FSM state encoding and square-index to one-hot move conversion.
package ttt_pkg;

    localparam int NUM_SQUARES = 9;

    typedef logic [NUM_SQUARES-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Square i (row-major, 0 = top-left) maps to board bit NUM_SQUARES-1-i.
    // Indices beyond the board produce an empty move.
    function automatic board_t square_onehot(input logic [3:0] idx);
        board_t v;
        v = '0;
        for (int i = 0; i < NUM_SQUARES; i++) begin
            if (idx == 4'(i)) begin
                v[NUM_SQUARES-1-i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioning: 2-flop synchronizer, optional debouncer (macro
// DEBOUNCE_EN) and registered rising-edge detector producing a 1-cycle press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic [1:0] primed;
    logic       armed;
    logic       level_d;

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          level_q;

    // Down-counter restarts whenever the sample agrees with the accepted level;
    // terminal count after DEBOUNCE_CYCLES disagreeing samples flips the level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (sync2 == level_q) begin
            cnt <= CNT_LOAD;
        end else if (cnt == '0) begin
            level_q <= sync2;
            cnt     <= CNT_LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync2;
`endif

    // armed blocks presses until the synchronizer has refilled after reset and
    // shown the button released, so a button held through reset is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed  <= 2'b00;
            armed   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            primed  <= {primed[0], 1'b1};
            armed   <= armed | (primed[1] & ~sync2);
            level_d <= level;
            press   <= level & ~level_d & armed;
        end
    end

endmodule

// File: rtl/move_entry.sv
// Move entry controller: conditions the "go" button, validates the selected
// square and hands a one-hot move plus Go strobe to the game core.
// Optional debouncing of btn_go is enabled by defining DEBOUNCE_EN.
//
// state    | meaning
// IDLE     | waiting for a press event
// CHECK    | validating registered sel against board and game status
// ISSUE    | Go strobe, xin stable
// WAIT_REL | waiting for button release; bad_move checked in first cycle
module move_entry
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             sel,
    input  logic                   btn_go,
    input  logic [NUM_SQUARES-1:0] xin_star,
    input  logic [NUM_SQUARES-1:0] oin_star,
    input  logic                   playing_game,
    input  logic                   bad_move,
    output logic [NUM_SQUARES-1:0] xin,
    output logic                   Go,
    output logic                   entry_err,
    output logic                   busy
);

    state_t     state;
    state_t     next_state;
    logic       level;
    logic       press;
    logic [3:0] sel_q;
    logic       first_wait;
    logic       reject;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_go),
        .level(level),
        .press(press)
    );

    // Out-of-range indices give an empty one-hot, so only the range test catches them.
    always_comb begin
        reject = (sel_q > 4'd8)
               || ((square_onehot(sel_q) & (xin_star | oin_star)) != '0)
               || !playing_game;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= '0;
            xin        <= '0;
            first_wait <= 1'b0;
        end else begin
            state      <= next_state;
            first_wait <= (state == ISSUE);
            if (state == IDLE && press) begin
                sel_q <= sel;
            end
            if (state == CHECK && !reject) begin
                xin <= square_onehot(sel_q);
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (press) next_state = CHECK;
            CHECK:    next_state = reject ? WAIT_REL : ISSUE;
            ISSUE:    next_state = WAIT_REL;
            WAIT_REL: if (!level) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        Go        = (state == ISSUE);
        entry_err = ((state == CHECK) && reject)
                  || ((state == WAIT_REL) && first_wait && bad_move);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_move_entry.sv
// Self-checking bench for move_entry: directed scenarios followed by random
// press transactions compared cycle by cycle against a timing/behaviour model.
module tb_move_entry;

    localparam int DC = 4;
`ifdef DEBOUNCE_EN
    localparam int D = DC;
`else
    localparam int D = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sel;
    logic       btn_go;
    logic [8:0] xin_star;
    logic [8:0] oin_star;
    logic       playing_game;
    logic       bad_move;
    logic [8:0] xin;
    logic       go_s;
    logic       entry_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [8:0] xin_model = 9'h0;

    always #5 clk = ~clk;

    move_entry #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .btn_go      (btn_go),
        .xin_star    (xin_star),
        .oin_star    (oin_star),
        .playing_game(playing_game),
        .bad_move    (bad_move),
        .xin         (xin),
        .Go          (go_s),
        .entry_err   (entry_err),
        .busy        (busy)
    );

    function automatic logic [8:0] onehot_ref(input int s);
        logic [8:0] top;
        top = 9'h100;
        return (s >= 0 && s <= 8) ? (top >> s) : 9'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One press transaction; cycle k is the sample after the k-th rising edge,
    // edge 1 being the first edge that sees btn_go high.
    task automatic run_press(input int s, input logic [8:0] xs, input logic [8:0] os,
                             input logic play, input logic bad, input int hold);
        bit         accept;
        logic [8:0] prev;
        int         n;
        accept = (s <= 8) && ((onehot_ref(s) & (xs | os)) == 9'h0) && play;
        prev = xin_model;
        if (accept) xin_model = onehot_ref(s);
        sel          = 4'(s);
        xin_star     = xs;
        oin_star     = os;
        playing_game = play;
        btn_go       = 1'b1;
        n = hold + 6 + D;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("go", 32'(go_s), 32'(accept && k == 5 + D));
            chk("entry_err", 32'(entry_err),
                32'((!accept && k == 4 + D) || (accept && bad && k == 6 + D)));
            chk("busy", 32'(busy), 32'(k >= 4 + D && k <= hold + 2 + D));
            chk("xin", 32'(xin), 32'((k >= 5 + D) ? xin_model : prev));
            if (k == hold) btn_go = 1'b0;
            if (k >= 4 + D) sel = 4'($urandom_range(0, 15));
            bad_move = (k == 5 + D) ? bad : 1'($urandom_range(0, 1));
        end
        bad_move = 1'b0;
    endtask

    initial begin
        int         s;
        logic [8:0] xs;
        logic [8:0] os;
        reset        = 1'b1;
        sel          = 4'd0;
        btn_go       = 1'b0;
        xin_star     = 9'h0;
        oin_star     = 9'h0;
        playing_game = 1'b1;
        bad_move     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_xin", 32'(xin), 32'h0);
        chk("rst_go", 32'(go_s), 32'h0);
        chk("rst_err", 32'(entry_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (4 + D) @(negedge clk);

        // Accepted move on empty board, square 0.
        run_press(0, 9'h0, 9'h0, 1'b1, 1'b0, 6 + D);
        // Occupied square 8, out-of-range selections, game not running.
        run_press(8, 9'b000_000_001, 9'h0, 1'b1, 1'b0, 6 + D);
        run_press(9, 9'h0, 9'h0, 1'b1, 1'b0, 7 + D);
        run_press(15, 9'h0, 9'h0, 1'b1, 1'b0, 7 + D);
        run_press(4, 9'h0, 9'h0, 1'b0, 1'b0, 7 + D);
        // Illegal-move flag right after Go.
        run_press(3, 9'h0, 9'h0, 1'b1, 1'b1, 9 + D);

`ifdef DEBOUNCE_EN
        // Short glitch must not survive the debouncer.
        btn_go = 1'b1;
        repeat (2) @(negedge clk);
        btn_go = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("glitch_go", 32'(go_s), 32'h0);
            chk("glitch_busy", 32'(busy), 32'h0);
        end
        run_press(5, 9'h0, 9'h0, 1'b1, 1'b0, 10);
`endif

        // Reset while in ISSUE with the button held.
        sel          = 4'd2;
        xin_star     = 9'h0;
        oin_star     = 9'h0;
        playing_game = 1'b1;
        btn_go       = 1'b1;
        for (int k = 1; k <= 5 + D; k++) begin
            @(negedge clk);
            chk("pre_rst_go", 32'(go_s), 32'(k == 5 + D));
        end
        reset = 1'b1;
        xin_model = 9'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12 + D; k++) begin
            @(negedge clk);
            chk("held_go", 32'(go_s), 32'h0);
            chk("held_busy", 32'(busy), 32'h0);
            chk("held_xin", 32'(xin), 32'h0);
            chk("held_err", 32'(entry_err), 32'h0);
        end
        btn_go = 1'b0;
        repeat (4 + D) @(negedge clk);
        run_press(2, 9'h0, 9'h0, 1'b1, 1'b0, 6 + D);

        for (int t = 0; t < 20; t++) begin
            s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15))
                                             : int'($urandom_range(0, 8));
            xs = ($urandom_range(0, 2) == 0) ? 9'h0 : 9'($urandom_range(0, 511));
            os = 9'($urandom_range(0, 511)) & ~xs;
            run_press(s, xs, os, 1'($urandom_range(0, 5) != 0),
                      1'($urandom_range(0, 2) == 0), int'($urandom_range(6 + D, 10 + D)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port sel, input, 4, the player-selected square index 0..8 (0 = top-left, row-major).
REQ-005 SHALL have port btn_go, input, 1, the raw asynchronous "enter move" push-button.
REQ-006 SHALL have port xin_star, input, 9, the board squares already held by X, from the game core.
REQ-007 SHALL have port oin_star, input, 9, the board squares already held by O, from the game core.
REQ-008 SHALL have port playing_game, input, 1, high while the game core accepts moves.
REQ-009 SHALL have port bad_move, input, 1, the game core's illegal-move flag.
REQ-010 SHALL have port xin, output, 9, the one-hot move for the game core (square i drives bit 8-i).
REQ-011 SHALL have port Go, output, 1, a single-cycle move strobe to the game core.
REQ-012 SHALL have port entry_err, output, 1, a single-cycle pulse flagging a rejected entry.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL pass btn_go through a 2-flop synchronizer, then (see Configuration) the debouncer, then a rising-edge detector, producing a 1-cycle press event.
REQ-015 SHALL implement the FSM states IDLE, CHECK, ISSUE, WAIT_REL.
REQ-016 IDLE SHALL go to CHECK on a press event and register sel in that same cycle; press events outside IDLE are ignored.
REQ-017 CHECK SHALL reject the entry when sel > 8, when the square is set in (xin_star | oin_star), or when playing_game is 0; a rejection pulses entry_err for 1 cycle, leaves xin unchanged and goes to WAIT_REL.
REQ-018 CHECK SHALL otherwise load xin with the one-hot of the registered sel and go to ISSUE.
REQ-019 ISSUE SHALL drive Go=1 for exactly one cycle, with xin already stable in that cycle, then go to WAIT_REL.
REQ-020 WAIT_REL SHALL return to IDLE when the conditioned button level is 0.
REQ-021 bad_move sampled high in WAIT_REL during the first cycle after ISSUE SHALL pulse entry_err for 1 cycle.
REQ-022 xin SHALL hold its value until the next accepted move or reset; Go and entry_err are never high in the same cycle.
REQ-023 With DEBOUNCE_EN undefined, Go SHALL first be high in the cycle that starts at the 5th rising clk edge after btn_go is first sampled high.

Reset
REQ-024 Reset SHALL force: state IDLE, xin=0, Go=0, entry_err=0, busy=0, synchronizer and debounce counter cleared.
REQ-025 Reset asserted mid-operation (CHECK, ISSUE or WAIT_REL) SHALL abort the operation with no Go emitted after reset deasserts; a button still held at deassert SHALL NOT produce a press event until it is released and pressed again.

Configuration
REQ-026 Macro DEBOUNCE_EN defined SHALL make the conditioned level change only after DEBOUNCE_CYCLES consecutive equal synchronized samples, with the counter restarting on any mismatch, adding DEBOUNCE_CYCLES cycles of latency.
REQ-027 Macro DEBOUNCE_EN undefined SHALL make the conditioned level equal to the synchronizer output, with no counter logic instantiated.

Structure
REQ-028 Package ttt_pkg SHALL hold NUM_SQUARES=9, the FSM state enum, and a function converting a square index to the one-hot move.
REQ-029 The synchronizer, debouncer and edge detector SHALL form the sub-module btn_conditioner (outputs: level, press).

Verification
REQ-030 Scenario, no DEBOUNCE_EN, empty board, playing_game=1: sel=0, btn_go held 6 cycles -> xin=100_000_000, Go high exactly 1 cycle, 5 edges after the press.
REQ-031 Scenario: X holds sel 8 (xin_star=000_000_001), press with sel=8 -> entry_err 1 cycle, Go stays 0, xin unchanged.
REQ-032 Scenario: press with sel=9 or sel=15 -> entry_err 1 cycle, no Go; press with playing_game=0 -> entry_err 1 cycle, no Go.
REQ-033 Scenario, DEBOUNCE_EN, DEBOUNCE_CYCLES=4: btn_go glitches high 2 cycles -> no Go; then held 10 cycles -> exactly one Go.
REQ-034 Scenario: reset asserted in ISSUE with btn_go held, then deasserted -> xin=0, Go=0 and busy=0 until btn_go is released and pressed again.
REQ-035 Scenario: bad_move=1 in the cycle after Go -> entry_err 1 cycle; busy stays high until the button is released.
